// File: rtl/mic_regfile.sv
// Mic-1 register stage: shifter onto the C bus, nine C-bus registers plus MBR,
// latched ALU flags and the B-bus source mux.
module mic_regfile #(
  parameter int unsigned NBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] alu_c,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic [1:0]       shift,
  input  logic [8:0]       c_sel,
  input  logic [3:0]       b_sel,
  input  logic             mem_rd_valid,
  input  logic [NBITS-1:0] mem_rd_data,
  input  logic             fetch_valid,
  input  logic [7:0]       fetch_data,
  output logic [NBITS-1:0] c_bus,
  output logic [NBITS-1:0] b_bus,
  output logic [NBITS-1:0] h_out,
  output logic             flag_n,
  output logic             flag_z,
  output logic [NBITS-1:0] mar_out,
  output logic [NBITS-1:0] mdr_out,
  output logic [NBITS-1:0] pc_out,
  output logic [7:0]       mbr_out
);

  logic [NBITS-1:0] h_q, opc_q, tos_q, cpp_q, lv_q, sp_q, pc_q, mdr_q, mar_q;
  logic [NBITS-1:0] mdr_d;
  logic [7:0]       mbr_q;
  logic             flag_n_q, flag_z_q;
  logic [NBITS-1:0] sll8;

  // SLL8 is applied before SRA1 when both shift bits are set.
  always_comb begin
    sll8  = shift[1] ? {alu_c[NBITS-9:0], 8'h00} : alu_c;
    c_bus = shift[0] ? {sll8[NBITS-1], sll8[NBITS-1:1]} : sll8;
  end

  // Memory read data takes precedence over a C-bus write to MDR.
  always_comb begin
    mdr_d = mdr_q;
    if (c_sel[1])     mdr_d = c_bus;
    if (mem_rd_valid) mdr_d = mem_rd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q      <= '0;
      opc_q    <= '0;
      tos_q    <= '0;
      cpp_q    <= '0;
      lv_q     <= '0;
      sp_q     <= '0;
      pc_q     <= '0;
      mdr_q    <= '0;
      mar_q    <= '0;
      mbr_q    <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      if (c_sel[8]) h_q   <= c_bus;
      if (c_sel[7]) opc_q <= c_bus;
      if (c_sel[6]) tos_q <= c_bus;
      if (c_sel[5]) cpp_q <= c_bus;
      if (c_sel[4]) lv_q  <= c_bus;
      if (c_sel[3]) sp_q  <= c_bus;
      if (c_sel[2]) pc_q  <= c_bus;
      if (c_sel[0]) mar_q <= c_bus;
      mdr_q <= mdr_d;
      if (fetch_valid) mbr_q <= fetch_data;
      flag_n_q <= alu_n;
      flag_z_q <= alu_z;
    end
  end

  always_comb begin
    b_bus = '0;
    case (b_sel)
      4'd0:    b_bus = mdr_q;
      4'd1:    b_bus = pc_q;
      4'd2:    b_bus = {{(NBITS-8){mbr_q[7]}}, mbr_q};
      4'd3:    b_bus = {{(NBITS-8){1'b0}}, mbr_q};
      4'd4:    b_bus = sp_q;
      4'd5:    b_bus = lv_q;
      4'd6:    b_bus = cpp_q;
      4'd7:    b_bus = tos_q;
      4'd8:    b_bus = opc_q;
      default: b_bus = '0;
    endcase
  end

  assign h_out   = h_q;
  assign flag_n  = flag_n_q;
  assign flag_z  = flag_z_q;
  assign mar_out = mar_q;
  assign mdr_out = mdr_q;
  assign pc_out  = pc_q;
  assign mbr_out = mbr_q;

endmodule

// File: tb/tb_mic_regfile.sv
// Directed bench for mic_regfile; expected values are hand-computed constants.
module tb_mic_regfile;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_c;
  logic        alu_n;
  logic        alu_z;
  logic [1:0]  shift;
  logic [8:0]  c_sel;
  logic [3:0]  b_sel;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        fetch_valid;
  logic [7:0]  fetch_data;
  logic [31:0] c_bus;
  logic [31:0] b_bus;
  logic [31:0] h_out;
  logic        flag_n;
  logic        flag_z;
  logic [31:0] mar_out;
  logic [31:0] mdr_out;
  logic [31:0] pc_out;
  logic [7:0]  mbr_out;

  int n_cmp;
  int n_fail;

  mic_regfile #(.NBITS(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_c        (alu_c),
    .alu_n        (alu_n),
    .alu_z        (alu_z),
    .shift        (shift),
    .c_sel        (c_sel),
    .b_sel        (b_sel),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .fetch_valid  (fetch_valid),
    .fetch_data   (fetch_data),
    .c_bus        (c_bus),
    .b_bus        (b_bus),
    .h_out        (h_out),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .mar_out      (mar_out),
    .mdr_out      (mdr_out),
    .pc_out       (pc_out),
    .mbr_out      (mbr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_sel        = 9'h000;
    mem_rd_valid = 1'b0;
    fetch_valid  = 1'b0;
    shift        = 2'b00;
    alu_n        = 1'b0;
    alu_z        = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; c_sel = 9'h1FF; alu_c = 32'hFFFF_FFFF; mem_rd_valid = 1'b1;
    mem_rd_data = 32'hFFFF_FFFF; fetch_valid = 1'b1; fetch_data = 8'hFF;
    alu_n = 1'b1; alu_z = 1'b1;
    step();
    step();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (h_out !== 32'h0) begin n_fail++; $display("FAIL reset_h got %h want 0", h_out); end
    n_cmp++; if (mar_out !== 32'h0) begin n_fail++; $display("FAIL reset_mar got %h want 0", mar_out); end
    n_cmp++; if (mdr_out !== 32'h0) begin n_fail++; $display("FAIL reset_mdr got %h want 0", mdr_out); end
    n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc_out); end
    n_cmp++; if (mbr_out !== 8'h0) begin n_fail++; $display("FAIL reset_mbr got %h want 0", mbr_out); end
    n_cmp++; if (flag_n !== 1'b0) begin n_fail++; $display("FAIL reset_flag_n got %b want 0", flag_n); end
    n_cmp++; if (flag_z !== 1'b0) begin n_fail++; $display("FAIL reset_flag_z got %b want 0", flag_z); end
    for (int i = 0; i <= 8; i++) begin
      b_sel = 4'(i);
      #1;
      n_cmp++;
      if (b_bus !== 32'h0) begin
        n_fail++; $display("FAIL reset_b_bus sel=%0d got %h want 0", i, b_bus);
      end
    end
  endtask

  task automatic test_shifter();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'h8000_00F1;
    exp_tab[1] = 32'hC000_0078;
    exp_tab[2] = 32'h0000_F100;
    exp_tab[3] = 32'h0000_7880;
    alu_c = 32'h8000_00F1;
    for (int i = 0; i < 4; i++) begin
      shift = 2'(i);
      #1;
      n_cmp++;
      if (c_bus !== exp_tab[i]) begin
        n_fail++; $display("FAIL shifter shift=%0d got %h want %h", i, c_bus, exp_tab[i]);
      end
    end
    shift = 2'b00;
  endtask

  // Load each C-bus register with a distinct value, then check every B-bus source.
  task automatic test_bsel_map();
    logic [3:0]  sel_tab [7];
    logic [31:0] exp_tab [7];
    for (int i = 0; i <= 8; i++) begin
      c_sel = 9'(1 << i);
      alu_c = 32'h100 + 32'(i);
      step();
    end
    c_sel = 9'h000;
    sel_tab[0] = 4'd0; exp_tab[0] = 32'h101;
    sel_tab[1] = 4'd1; exp_tab[1] = 32'h102;
    sel_tab[2] = 4'd4; exp_tab[2] = 32'h103;
    sel_tab[3] = 4'd5; exp_tab[3] = 32'h104;
    sel_tab[4] = 4'd6; exp_tab[4] = 32'h105;
    sel_tab[5] = 4'd7; exp_tab[5] = 32'h106;
    sel_tab[6] = 4'd8; exp_tab[6] = 32'h107;
    for (int i = 0; i < 7; i++) begin
      b_sel = sel_tab[i];
      #1;
      n_cmp++;
      if (b_bus !== exp_tab[i]) begin
        n_fail++; $display("FAIL bsel_map sel=%0d got %h want %h", sel_tab[i], b_bus, exp_tab[i]);
      end
    end
    n_cmp++; if (h_out !== 32'h108) begin n_fail++; $display("FAIL map_h got %h want 108", h_out); end
    n_cmp++; if (mar_out !== 32'h100) begin n_fail++; $display("FAIL map_mar got %h want 100", mar_out); end
  endtask

  task automatic test_multi_write();
    c_sel = 9'h10C; alu_c = 32'h1234; shift = 2'b00; b_sel = 4'd1;
    #1;
    n_cmp++; if (b_bus !== 32'h102) begin n_fail++; $display("FAIL no_bypass_pc got %h want 102", b_bus); end
    n_cmp++; if (h_out !== 32'h108) begin n_fail++; $display("FAIL no_bypass_h got %h want 108", h_out); end
    step();
    c_sel = 9'h000;
    n_cmp++; if (h_out !== 32'h1234) begin n_fail++; $display("FAIL multi_h got %h want 1234", h_out); end
    n_cmp++; if (pc_out !== 32'h1234) begin n_fail++; $display("FAIL multi_pc got %h want 1234", pc_out); end
    b_sel = 4'd4;
    #1;
    n_cmp++; if (b_bus !== 32'h1234) begin n_fail++; $display("FAIL multi_sp got %h want 1234", b_bus); end
    b_sel = 4'd5;
    #1;
    n_cmp++; if (b_bus !== 32'h104) begin n_fail++; $display("FAIL multi_lv_hold got %h want 104", b_bus); end
    n_cmp++; if (mar_out !== 32'h100) begin n_fail++; $display("FAIL multi_mar_hold got %h want 100", mar_out); end
  endtask

  task automatic test_mdr_conflict();
    c_sel = 9'h003; alu_c = 32'hAAAA; mem_rd_valid = 1'b1; mem_rd_data = 32'h5555;
    step();
    c_sel = 9'h000; mem_rd_valid = 1'b0;
    n_cmp++; if (mdr_out !== 32'h5555) begin n_fail++; $display("FAIL mdr_conflict got %h want 5555", mdr_out); end
    n_cmp++; if (mar_out !== 32'hAAAA) begin n_fail++; $display("FAIL mdr_conflict_mar got %h want aaaa", mar_out); end
    mem_rd_data = 32'h9999;
    step();
    n_cmp++; if (mdr_out !== 32'h5555) begin n_fail++; $display("FAIL mdr_no_strobe got %h want 5555", mdr_out); end
    c_sel = 9'h002; alu_c = 32'h7777;
    step();
    c_sel = 9'h000;
    n_cmp++; if (mdr_out !== 32'h7777) begin n_fail++; $display("FAIL mdr_cbus got %h want 7777", mdr_out); end
  endtask

  task automatic test_mbr_ext();
    fetch_valid = 1'b1; fetch_data = 8'h9C;
    step();
    fetch_valid = 1'b0; fetch_data = 8'h11;
    n_cmp++; if (mbr_out !== 8'h9C) begin n_fail++; $display("FAIL mbr_load got %h want 9c", mbr_out); end
    b_sel = 4'd2;
    #1;
    n_cmp++; if (b_bus !== 32'hFFFF_FF9C) begin n_fail++; $display("FAIL mbr_sext got %h want ffffff9c", b_bus); end
    b_sel = 4'd3;
    #1;
    n_cmp++; if (b_bus !== 32'h0000_009C) begin n_fail++; $display("FAIL mbr_zext got %h want 0000009c", b_bus); end
    b_sel = 4'd12;
    #1;
    n_cmp++; if (b_bus !== 32'h0) begin n_fail++; $display("FAIL bsel_reserved got %h want 0", b_bus); end
    step();
    n_cmp++; if (mbr_out !== 8'h9C) begin n_fail++; $display("FAIL mbr_no_strobe got %h want 9c", mbr_out); end
    fetch_valid = 1'b1; fetch_data = 8'h5A;
    step();
    fetch_valid = 1'b0;
    b_sel = 4'd2;
    #1;
    n_cmp++; if (b_bus !== 32'h0000_005A) begin n_fail++; $display("FAIL mbr_sext_pos got %h want 5a", b_bus); end
  endtask

  task automatic test_flags_reset();
    alu_n = 1'b1; alu_z = 1'b0; shift = 2'b10; alu_c = 32'h0000_0001;
    step();
    n_cmp++; if (flag_n !== 1'b1) begin n_fail++; $display("FAIL flag_n_set got %b want 1", flag_n); end
    n_cmp++; if (flag_z !== 1'b0) begin n_fail++; $display("FAIL flag_z_clr got %b want 0", flag_z); end
    // Flags follow the ALU, not c_bus: alu_c is nonzero but alu_z is asserted.
    alu_n = 1'b0; alu_z = 1'b1; shift = 2'b00; alu_c = 32'h8000_0000;
    step();
    n_cmp++; if (flag_n !== 1'b0) begin n_fail++; $display("FAIL flag_n_clr got %b want 0", flag_n); end
    n_cmp++; if (flag_z !== 1'b1) begin n_fail++; $display("FAIL flag_z_set got %b want 1", flag_z); end
    rst_n = 1'b0; c_sel = 9'h1FF; alu_c = 32'hFFFF_FFFF; alu_n = 1'b1; alu_z = 1'b1;
    mem_rd_valid = 1'b1; fetch_valid = 1'b1; fetch_data = 8'hFF;
    step();
    rst_n = 1'b1;
    idle_inputs();
    #1;
    n_cmp++; if (flag_n !== 1'b0) begin n_fail++; $display("FAIL midreset_flag_n got %b want 0", flag_n); end
    n_cmp++; if (flag_z !== 1'b0) begin n_fail++; $display("FAIL midreset_flag_z got %b want 0", flag_z); end
    n_cmp++; if (h_out !== 32'h0) begin n_fail++; $display("FAIL midreset_h got %h want 0", h_out); end
    n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL midreset_pc got %h want 0", pc_out); end
    n_cmp++; if (mdr_out !== 32'h0) begin n_fail++; $display("FAIL midreset_mdr got %h want 0", mdr_out); end
    n_cmp++; if (mar_out !== 32'h0) begin n_fail++; $display("FAIL midreset_mar got %h want 0", mar_out); end
    n_cmp++; if (mbr_out !== 8'h0) begin n_fail++; $display("FAIL midreset_mbr got %h want 0", mbr_out); end
    for (int i = 0; i <= 8; i++) begin
      b_sel = 4'(i);
      #1;
      n_cmp++;
      if (b_bus !== 32'h0) begin
        n_fail++; $display("FAIL midreset_b_bus sel=%0d got %h want 0", i, b_bus);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    alu_c = '0;
    b_sel = '0;
    mem_rd_data = '0;
    fetch_data = '0;
    idle_inputs();
    test_reset();
    test_shifter();
    test_bsel_map();
    test_multi_write();
    test_mdr_conflict();
    test_mbr_ext();
    test_flags_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
